// File: rtl/uart_pkg.sv
// uart_pkg: shared UART timing constants and divider/increment constant functions.
`default_nettype none

package uart_pkg;

   localparam int unsigned OVERSAMPLE = 16;
   localparam int unsigned FRAC_ACC_W = 16;

   // Round-to-nearest integer divide giving clocks per 16x oversample tick.
   function automatic int unsigned calc_rx_div(input int unsigned clock_freq,
                                               input int unsigned baud);
      longint unsigned num;
      longint unsigned den;
      if (baud == 0) return 1;
      num = longint'(clock_freq) + longint'(baud) * (OVERSAMPLE / 2);
      den = longint'(baud) * OVERSAMPLE;
      return int'(num / den);
   endfunction

   // Rounded phase increment for a FRAC_ACC_W-bit accumulator at 16x baud.
   function automatic int unsigned calc_frac_inc(input int unsigned clock_freq,
                                                 input int unsigned baud);
      longint unsigned num;
      if (clock_freq == 0) return 1;
      num = longint'(baud) * OVERSAMPLE * (longint'(1) << FRAC_ACC_W);
      return int'((num + longint'(clock_freq) / 2) / longint'(clock_freq));
   endfunction

endpackage

`default_nettype wire

// File: rtl/baud_rate_generator.sv
// ============================================================================
//  Module  : baud_rate_generator
//  Purpose : UART 16x oversample (rx) and 1x bit (tx) strobes from clk.
//            Define BAUD_FRAC_EN to use a fractional phase accumulator
//            instead of the integer divider.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module baud_rate_generator
   import uart_pkg::*;
#(
   parameter int unsigned CLOCK_FREQ = 50_000_000,
   parameter int unsigned BAUD_RATE  = 115200
) (
   input  logic clk,
   input  logic rst,
   output logic tx_baud_tick,
   output logic rx_baud_tick
);

   localparam int unsigned c_OS_W = $clog2(OVERSAMPLE);
   localparam logic [c_OS_W-1:0] c_OS_LAST = c_OS_W'(OVERSAMPLE - 1);

   generate
      if (BAUD_RATE == 0 ||
          longint'(CLOCK_FREQ) < longint'(OVERSAMPLE) * longint'(BAUD_RATE)) begin : g_bad_cfg
         $fatal(1, "baud_rate_generator: CLOCK_FREQ must be >= 16*BAUD_RATE and BAUD_RATE > 0");
      end
   endgenerate

   logic              w_rx_evt;
   logic [c_OS_W-1:0] r_os_cnt;

`ifdef BAUD_FRAC_EN
   localparam logic [FRAC_ACC_W:0] c_INC =
      (FRAC_ACC_W + 1)'(calc_frac_inc(CLOCK_FREQ, BAUD_RATE));

   logic [FRAC_ACC_W-1:0] r_acc;
   logic [FRAC_ACC_W:0]   w_sum;

   // The extra sum bit is the carry; it also covers INC == 2^16 (tick every clk).
   assign w_sum    = {1'b0, r_acc} + c_INC;
   assign w_rx_evt = w_sum[FRAC_ACC_W];

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_acc <= '0;
      end else begin
         r_acc <= w_sum[FRAC_ACC_W-1:0];
      end
   end
`else
   localparam int unsigned c_RX_DIV = calc_rx_div(CLOCK_FREQ, BAUD_RATE);
   localparam int unsigned c_DIV_W  = (c_RX_DIV > 1) ? $clog2(c_RX_DIV) : 1;
   localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(c_RX_DIV - 1);

   logic [c_DIV_W-1:0] r_div_cnt;

   assign w_rx_evt = (r_div_cnt == c_DIV_LAST);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_div_cnt <= '0;
      end else if (w_rx_evt) begin
         r_div_cnt <= '0;
      end else begin
         r_div_cnt <= r_div_cnt + 1'b1;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_os_cnt     <= '0;
         rx_baud_tick <= 1'b0;
         tx_baud_tick <= 1'b0;
      end else begin
         rx_baud_tick <= w_rx_evt;
         tx_baud_tick <= w_rx_evt && (r_os_cnt == c_OS_LAST);
         if (w_rx_evt) begin
            r_os_cnt <= r_os_cnt + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_baud_rate_generator.sv
// Randomized reset-pulse stimulus on three configurations, checked cycle by
// cycle against a tick-count model derived from elapsed clocks since reset.
`default_nettype none

module tb_baud_rate_generator;

   logic clk;
   logic rst;
   logic tx_a, rx_a, tx_b, rx_b, tx_c, rx_c;

   int unsigned n_vec;
   int unsigned n_bad;
   longint unsigned k;
   longint unsigned cyc;

   baud_rate_generator #(.CLOCK_FREQ(50_000_000), .BAUD_RATE(115200)) u_def (
      .clk(clk), .rst(rst), .tx_baud_tick(tx_a), .rx_baud_tick(rx_a));
   baud_rate_generator #(.CLOCK_FREQ(50_000_000), .BAUD_RATE(460800)) u_fast (
      .clk(clk), .rst(rst), .tx_baud_tick(tx_b), .rx_baud_tick(rx_b));
   baud_rate_generator #(.CLOCK_FREQ(1_843_200), .BAUD_RATE(115200)) u_edge (
      .clk(clk), .rst(rst), .tx_baud_tick(tx_c), .rx_baud_tick(rx_c));

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // round(f / (16*b)) and round(16*b*2^16 / f), written as plain arithmetic
   function automatic longint unsigned ref_div(input longint unsigned f, input longint unsigned b);
      return (2 * f + 16 * b) / (32 * b);
   endfunction

   function automatic longint unsigned ref_inc(input longint unsigned f, input longint unsigned b);
      return (b * 16 * 65536 * 2 + f) / (2 * f);
   endfunction

   // Number of rx ticks generated after n clocks of free running.
   function automatic longint unsigned n_ticks(input longint unsigned n,
                                               input longint unsigned f,
                                               input longint unsigned b);
`ifdef BAUD_FRAC_EN
      return (n * ref_inc(f, b)) >> 16;
`else
      return n / ref_div(f, b);
`endif
   endfunction

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d k=%0d got=%0b exp=%0b", tag, cyc, k, obs, exp);
      end
   endtask

   task automatic chk_cfg(input string tag, input logic rx, input logic tx,
                          input longint unsigned f, input longint unsigned b);
      logic e_rx, e_tx;
      longint unsigned now_t;
      now_t = n_ticks(k, f, b);
      e_rx  = (k != 0) && (now_t != n_ticks(k - 1, f, b));
      e_tx  = e_rx && (now_t % 16 == 0);
      chk({tag, "_rx"}, rx, e_rx);
      chk({tag, "_tx"}, tx, e_tx);
   endtask

   task automatic chk_all();
      chk_cfg("def",  rx_a, tx_a, 50_000_000, 115200);
      chk_cfg("fast", rx_b, tx_b, 50_000_000, 460800);
      chk_cfg("edge", rx_c, tx_c, 1_843_200,  115200);
   endtask

   initial begin
      int unsigned seg_len;
      int unsigned rst_len;
      n_vec = 0;
      n_bad = 0;
      cyc   = 0;
      k     = 0;
      rst   = 1'b0;
      repeat (2) @(posedge clk);
      for (int s = 0; s < 28; s++) begin
         if (s == 0)      seg_len = 66000;
         else if (s == 1) seg_len = 13;
         else             seg_len = $urandom_range(1, 800);
         for (int c = 0; c < int'(seg_len); c++) begin
            @(negedge clk);
            chk_all();
            rst = 1'b1;
            @(posedge clk);
            k++;
            cyc++;
         end
         rst_len = $urandom_range(1, 3);
         for (int r = 0; r < int'(rst_len); r++) begin
            @(negedge clk);
            chk_all();
            rst = 1'b0;
            @(posedge clk);
            k = 0;
            cyc++;
         end
      end
      @(negedge clk);
      chk_all();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/baud_rate_generator.md
Name: baud_rate_generator

Overview:
Free-running UART timing source. Derives two single-cycle strobes from the system clock:
- rx_baud_tick at 16x the baud rate, which drives receiver oversampling.
- tx_baud_tick at 1x the baud rate, which drives transmitter bit timing.

It sits beside uart_tx and uart_rx and feeds both. There is no data path.

Parameters:
- CLOCK_FREQ, default 50_000_000: system clock frequency in Hz.
- BAUD_RATE, default 115200: target baud rate in Hz.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- tx_baud_tick  output  1  one-clk pulse at BAUD_RATE.
- rx_baud_tick  output  1  one-clk pulse at 16*BAUD_RATE.

Behaviour:
- Elaboration check: require CLOCK_FREQ >= 16*BAUD_RATE and BAUD_RATE > 0. Otherwise raise a fatal elaboration error.
- RX_DIV = (CLOCK_FREQ + 8*BAUD_RATE) / (16*BAUD_RATE), i.e. round-to-nearest integer division; RX_DIV >= 1.
- Divider counter width is max(1, $clog2(RX_DIV)).
- Reset (rst==0 at clk edge):
  - divider counter <= 0, oversample counter (4 bit) <= 0.
  - rx_baud_tick <= 0, tx_baud_tick <= 0.
  - Reset overrides everything and is valid mid-operation; it restarts phase from zero.
- Each non-reset edge:
  - If div_cnt == RX_DIV-1: div_cnt <= 0, rx_baud_tick <= 1, os_cnt <= os_cnt+1 (wraps 15->0).
  - Else: div_cnt <= div_cnt+1, rx_baud_tick <= 0.
  - tx_baud_tick <= 1 only when div_cnt == RX_DIV-1 and os_cnt == 15; else 0.
- Both outputs are registered, with no combinational path from inputs.
- First rx tick is high during the cycle after the RX_DIV-th rising edge following reset release. Period is exactly RX_DIV cycles, high for 1 cycle.
- tx tick coincides with every 16th rx tick, the first on the 16th. Period is 16*RX_DIV cycles.
- Boundary RX_DIV==1: rx_baud_tick stays high continuously after the first post-reset edge; tx_baud_tick pulses once every 16 cycles.

Optional Feature:
- Macro: BAUD_FRAC_EN.
- When defined, the integer divider is replaced by a 16-bit phase accumulator:
  - INC = round(16*BAUD_RATE*65536/CLOCK_FREQ).
  - Each cycle acc <= acc+INC (mod 2^16).
  - rx_baud_tick <= carry-out of that add.
  - Average rx period is 65536/INC cycles; individual spacing is floor or ceil of that.
  - Reset clears acc.
- The os_cnt and tx_baud_tick logic is unchanged.
- When not defined, the integer RX_DIV behaviour above applies.

Decomposition:
- Package uart_pkg holds:
  - OVERSAMPLE = 16.
  - FRAC_ACC_W = 16.
  - Constant functions calc_rx_div(clock_freq, baud) and calc_frac_inc(clock_freq, baud).
- Single module, no sub-module required. The 4-bit oversample counter is small enough to stay inline.

Test Plan:
- Defaults (50 MHz, 115200): RX_DIV=27.
  - rx tick spacing is 27 clks (540 ns); 10 intervals = 5400 ns.
  - Derived tick freq 1,851,851.85 Hz; generated baud 115,740.74 Hz.
- BAUD_RATE=460800, 50 MHz: RX_DIV=7.
  - rx spacing 140 ns.
  - tx spacing 112 clks (2240 ns).
- Reset/phase:
  - Release rst; the first rx pulse appears after the 27th edge.
  - The first tx pulse appears simultaneously with the 16th rx pulse.
  - Ticks are never wider than 1 cycle.
  - Run 500 rx ticks and check that every tx pulse aligns with an rx pulse.
- Mid-operation reset:
  - Drive rst=0 for 1 cycle at div_cnt=13.
  - Both ticks are 0 the next cycle.
  - The next rx tick comes 27 edges after release, and os_cnt has restarted, so tx follows 16 rx ticks later.
- Boundary CLOCK_FREQ=1_843_200, BAUD_RATE=115200:
  - RX_DIV=1; rx stuck high after reset release; tx pulses every 16 clks.
  - Setting CLOCK_FREQ below 16*BAUD_RATE must fail elaboration.
- BAUD_FRAC_EN, defaults:
  - INC=2416.
  - Over 65536 clks, exactly 2416 rx ticks and 151 tx ticks.
  - Every rx spacing is 27 or 28 clks.
